vga_scan_ctrl: RTL and testbench

Scan controller that sequences the VGA pixel output stage. It generates raster timing (HSYNC/VSYNC/DE, H/V addresses) and schedules per-line fetches into the line buffers that feed the pixel stage through a req/ack handshake. It also double-buffers display configuration (mode, cursor enable, cursor point) so that changes take effect only at frame boundaries. It sits between the host/config logic, the line-buffer loader and the VGA output formatter.

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_line_fetch_fsm.sv | 89 ++++++++
 rtl/vga_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_vga_scan_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared raster timing helpers and fetch FSM state encoding
//                for the VGA scan controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Line-fetch FSM states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_t;

    // Total cycles (or lines) in one period: active + porches + sync
    function automatic int calc_total(input int active, input int fp, input int sw, input int bp);
        return active + fp + sw + bp;
    endfunction

    // First counter value at which sync is active
    function automatic int calc_sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    // First counter value past the sync pulse
    function automatic int calc_sync_end(input int active, input int fp, input int sw);
        return active + fp + sw;
    endfunction

    // Totals for the default 640x480 mode
    localparam int c_HTOTAL_DEFAULT = calc_total(640, 16, 96, 48);
    localparam int c_VTOTAL_DEFAULT = calc_total(480, 10, 2, 33);

endpackage
`default_nettype wire

// File: rtl/vga_line_fetch_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : vga_line_fetch_fsm
//  Description : Schedules one line-buffer fetch per displayed line during
//                horizontal blanking and flags fetches that miss the end of
//                the line as a sticky underflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_line_fetch_fsm
    import vga_timing_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int HACTIVE    = 640,
    parameter int HTOTAL     = 800,
    parameter int VACTIVE    = 480,
    parameter int VTOTAL     = 525
) (
    input  logic                  VCLK,
    input  logic                  RST_N,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] h_cnt,
    input  logic [ADDR_WIDTH-1:0] h_cnt_nxt,
    input  logic [ADDR_WIDTH-1:0] v_cnt_nxt,
    input  logic                  line_ack,
    input  logic                  underflow_clr,
    output logic                  line_req,
    output logic [ADDR_WIDTH-1:0] line_num,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH-1:0] c_H_ACT  = ADDR_WIDTH'(HACTIVE);
    localparam logic [ADDR_WIDTH-1:0] c_H_LAST = ADDR_WIDTH'(HTOTAL - 1);
    localparam logic [ADDR_WIDTH-1:0] c_V_ACT  = ADDR_WIDTH'(VACTIVE);
    localparam logic [ADDR_WIDTH-1:0] c_V_LAST = ADDR_WIDTH'(VTOTAL - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ONE    = ADDR_WIDTH'(1);

    fetch_state_t          r_state;
    logic [ADDR_WIDTH-1:0] w_target;
    logic                  w_miss;

    // Line needed next: the one after the line being entered, wrapping at frame end
    assign w_target = (v_cnt_nxt == c_V_LAST) ? '0 : (v_cnt_nxt + c_ONE);

    // Request still open on the last cycle of the line without an ack
    assign w_miss = en && (r_state == REQ) && !line_ack && (h_cnt == c_H_LAST);

    // Fetch FSM with registered request, line number and sticky underflow
    always_ff @(posedge VCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= IDLE;
            line_req  <= 1'b0;
            line_num  <= '0;
            underflow <= 1'b0;
        end else begin
            if (w_miss) begin
                underflow <= 1'b1;
            end else if (underflow_clr) begin
                underflow <= 1'b0;
            end

            if (!en) begin
                r_state  <= IDLE;
                line_req <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if ((h_cnt_nxt == c_H_ACT) && (w_target < c_V_ACT)) begin
                            r_state  <= REQ;
                            line_req <= 1'b1;
                            line_num <= w_target;
                        end
                    end
                    REQ: begin
                        if (line_ack || (h_cnt == c_H_LAST)) begin
                            r_state  <= IDLE;
                            line_req <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= IDLE;
                        line_req <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scan_ctrl
//  Description : VGA raster timing generator with frame-synchronous
//                configuration shadowing and line-fetch scheduling.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_ctrl
    import vga_timing_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int HACTIVE    = 640,
    parameter int HFP        = 16,
    parameter int HSW        = 96,
    parameter int HBP        = 48,
    parameter int VACTIVE    = 480,
    parameter int VFP        = 10,
    parameter int VSW        = 2,
    parameter int VBP        = 33,
    parameter bit SYNC_POL   = 1'b0
) (
    input  logic                  VCLK,
    input  logic                  RST_N,
    input  logic                  iEN,
    input  logic                  iCFG_VALID,
    input  logic                  iCFG_MODE,
    input  logic                  iCFG_CURSOR_EN,
    input  logic [ADDR_WIDTH-1:0] iCFG_POINT_X,
    input  logic [ADDR_WIDTH-1:0] iCFG_POINT_Y,
    output logic                  oCFG_ACK,
    output logic                  oHSYNC,
    output logic                  oVSYNC,
    output logic                  oDE,
    output logic [ADDR_WIDTH-1:0] oH_ADDR,
    output logic [ADDR_WIDTH-1:0] oV_ADDR,
    output logic                  oFRAME_START,
    output logic                  oVGAout_mode,
    output logic                  oCURSOR_EN,
    output logic [ADDR_WIDTH-1:0] oPOINT_X,
    output logic [ADDR_WIDTH-1:0] oPOINT_Y,
    output logic                  oLINE_REQ,
    output logic [ADDR_WIDTH-1:0] oLINE_NUM,
    input  logic                  iLINE_ACK,
    output logic                  oUNDERFLOW,
    input  logic                  iUNDERFLOW_CLR
);

    localparam int c_HTOTAL = calc_total(HACTIVE, HFP, HSW, HBP);
    localparam int c_VTOTAL = calc_total(VACTIVE, VFP, VSW, VBP);

    localparam logic [ADDR_WIDTH-1:0] c_H_ACT  = ADDR_WIDTH'(HACTIVE);
    localparam logic [ADDR_WIDTH-1:0] c_H_SS   = ADDR_WIDTH'(calc_sync_start(HACTIVE, HFP));
    localparam logic [ADDR_WIDTH-1:0] c_H_SE   = ADDR_WIDTH'(calc_sync_end(HACTIVE, HFP, HSW));
    localparam logic [ADDR_WIDTH-1:0] c_H_LAST = ADDR_WIDTH'(c_HTOTAL - 1);
    localparam logic [ADDR_WIDTH-1:0] c_V_ACT  = ADDR_WIDTH'(VACTIVE);
    localparam logic [ADDR_WIDTH-1:0] c_V_SS   = ADDR_WIDTH'(calc_sync_start(VACTIVE, VFP));
    localparam logic [ADDR_WIDTH-1:0] c_V_SE   = ADDR_WIDTH'(calc_sync_end(VACTIVE, VFP, VSW));
    localparam logic [ADDR_WIDTH-1:0] c_V_LAST = ADDR_WIDTH'(c_VTOTAL - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ONE    = ADDR_WIDTH'(1);

    logic                  r_run;
    logic [ADDR_WIDTH-1:0] r_h_cnt;
    logic [ADDR_WIDTH-1:0] r_v_cnt;
    logic [ADDR_WIDTH-1:0] w_h_nxt;
    logic [ADDR_WIDTH-1:0] w_v_nxt;
    logic                  w_wrap;
    logic                  r_cfg_pend;

    // Next raster position; the first enabled cycle presents (0,0) before counting
    always_comb begin
        w_h_nxt = '0;
        w_v_nxt = '0;
        if (iEN && r_run) begin
            if (r_h_cnt == c_H_LAST) begin
                w_h_nxt = '0;
                w_v_nxt = (r_v_cnt == c_V_LAST) ? '0 : (r_v_cnt + c_ONE);
            end else begin
                w_h_nxt = r_h_cnt + c_ONE;
                w_v_nxt = r_v_cnt;
            end
        end
    end

    assign w_wrap  = iEN && r_run && (r_h_cnt == c_H_LAST) && (r_v_cnt == c_V_LAST);
    assign oH_ADDR = r_h_cnt;
    assign oV_ADDR = r_v_cnt;

    // Counters and timing decode, registered together from the next position
    always_ff @(posedge VCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_run        <= 1'b0;
            r_h_cnt      <= '0;
            r_v_cnt      <= '0;
            oHSYNC       <= ~SYNC_POL;
            oVSYNC       <= ~SYNC_POL;
            oDE          <= 1'b0;
            oFRAME_START <= 1'b0;
        end else begin
            r_run        <= iEN;
            r_h_cnt      <= w_h_nxt;
            r_v_cnt      <= w_v_nxt;
            oDE          <= iEN && (w_h_nxt < c_H_ACT) && (w_v_nxt < c_V_ACT);
            oHSYNC       <= (iEN && (w_h_nxt >= c_H_SS) && (w_h_nxt < c_H_SE)) ? SYNC_POL : ~SYNC_POL;
            oVSYNC       <= (iEN && (w_v_nxt >= c_V_SS) && (w_v_nxt < c_V_SE)) ? SYNC_POL : ~SYNC_POL;
            oFRAME_START <= iEN && (w_h_nxt == '0) && (w_v_nxt == '0);
        end
    end

    // Config shadow: frame-boundary load while scanning, immediate load while stopped
    always_ff @(posedge VCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cfg_pend   <= 1'b0;
            oCFG_ACK     <= 1'b0;
            oVGAout_mode <= 1'b0;
            oCURSOR_EN   <= 1'b0;
            oPOINT_X     <= '0;
            oPOINT_Y     <= '0;
        end else begin
            oCFG_ACK   <= 1'b0;
            r_cfg_pend <= 1'b0;
            if (r_cfg_pend) begin
                oCFG_ACK <= 1'b1;
            end else if (iCFG_VALID && !oCFG_ACK && (iEN ? w_wrap : 1'b1)) begin
                oVGAout_mode <= iCFG_MODE;
                oCURSOR_EN   <= iCFG_CURSOR_EN;
                oPOINT_X     <= iCFG_POINT_X;
                oPOINT_Y     <= iCFG_POINT_Y;
                if (iEN) begin
                    oCFG_ACK <= 1'b1;
                end else begin
                    r_cfg_pend <= 1'b1;
                end
            end
        end
    end

    vga_line_fetch_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .HACTIVE    (HACTIVE),
        .HTOTAL     (c_HTOTAL),
        .VACTIVE    (VACTIVE),
        .VTOTAL     (c_VTOTAL)
    ) u_fetch (
        .VCLK          (VCLK),
        .RST_N         (RST_N),
        .en            (iEN),
        .h_cnt         (r_h_cnt),
        .h_cnt_nxt     (w_h_nxt),
        .v_cnt_nxt     (w_v_nxt),
        .line_ack      (iLINE_ACK),
        .underflow_clr (iUNDERFLOW_CLR),
        .line_req      (oLINE_REQ),
        .line_num      (oLINE_NUM),
        .underflow     (oUNDERFLOW)
    );

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_scan_ctrl
//  Description : Scoreboard bench for vga_scan_ctrl on a reduced 14x7 raster.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scan_ctrl;

    localparam int AW = 11;

    logic          VCLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          iEN = 1'b0;
    logic          iCFG_VALID = 1'b0;
    logic          iCFG_MODE = 1'b0;
    logic          iCFG_CURSOR_EN = 1'b0;
    logic [AW-1:0] iCFG_POINT_X = '0;
    logic [AW-1:0] iCFG_POINT_Y = '0;
    logic          iLINE_ACK = 1'b0;
    logic          iUNDERFLOW_CLR = 1'b0;
    logic          oCFG_ACK, oHSYNC, oVSYNC, oDE, oFRAME_START;
    logic          oVGAout_mode, oCURSOR_EN, oLINE_REQ, oUNDERFLOW;
    logic [AW-1:0] oH_ADDR, oV_ADDR, oPOINT_X, oPOINT_Y, oLINE_NUM;

    vga_scan_ctrl #(
        .ADDR_WIDTH(AW), .HACTIVE(8), .HFP(2), .HSW(2), .HBP(2),
        .VACTIVE(4), .VFP(1), .VSW(1), .VBP(1), .SYNC_POL(1'b0)
    ) dut (
        .VCLK(VCLK), .RST_N(RST_N), .iEN(iEN),
        .iCFG_VALID(iCFG_VALID), .iCFG_MODE(iCFG_MODE), .iCFG_CURSOR_EN(iCFG_CURSOR_EN),
        .iCFG_POINT_X(iCFG_POINT_X), .iCFG_POINT_Y(iCFG_POINT_Y), .oCFG_ACK(oCFG_ACK),
        .oHSYNC(oHSYNC), .oVSYNC(oVSYNC), .oDE(oDE),
        .oH_ADDR(oH_ADDR), .oV_ADDR(oV_ADDR), .oFRAME_START(oFRAME_START),
        .oVGAout_mode(oVGAout_mode), .oCURSOR_EN(oCURSOR_EN),
        .oPOINT_X(oPOINT_X), .oPOINT_Y(oPOINT_Y),
        .oLINE_REQ(oLINE_REQ), .oLINE_NUM(oLINE_NUM), .iLINE_ACK(iLINE_ACK),
        .oUNDERFLOW(oUNDERFLOW), .iUNDERFLOW_CLR(iUNDERFLOW_CLR)
    );

    always #5 VCLK = ~VCLK;

    typedef struct { logic [AW-1:0] v; logic [AW-1:0] h; logic [AW-1:0] num; logic [AW-1:0] fall; } req_t;
    typedef struct { logic [AW-1:0] v; logic [AW-1:0] h; logic req; } uf_t;
    typedef struct { logic fs; logic mode; logic cur; logic [AW-1:0] x; logic [AW-1:0] y; } cfg_t;

    req_t req_q[$];
    uf_t  uf_q[$];
    cfg_t cfg_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int withhold_line = -1;
    int late_line = -1;
    req_t cur_req;
    bit   have_cur = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_req(input int v, input int h, input int num, input int fall);
        req_t r;
        r.v = AW'(v); r.h = AW'(h); r.num = AW'(num); r.fall = AW'(fall);
        req_q.push_back(r);
    endtask

    task automatic push_frame(input int f0, input int f1, input int f2, input int f6);
        push_req(0, 8, 1, f0);
        push_req(1, 8, 2, f1);
        push_req(2, 8, 3, f2);
        push_req(6, 8, 0, f6);
    endtask

    task automatic push_uf(input int v, input int h);
        uf_t u;
        u.v = AW'(v); u.h = AW'(h); u.req = 1'b0;
        uf_q.push_back(u);
    endtask

    task automatic push_cfg(input logic fs, input logic mode, input logic cur, input int x, input int y);
        cfg_t c;
        c.fs = fs; c.mode = mode; c.cur = cur; c.x = AW'(x); c.y = AW'(y);
        cfg_q.push_back(c);
    endtask

    // Advance at least one cycle, then until the raster reaches (h,v)
    task automatic wait_pos(input int h, input int v);
        int n;
        n = 0;
        do begin
            @(negedge VCLK);
            n++;
        end while (!((oH_ADDR == AW'(h)) && (oV_ADDR == AW'(v))) && (n < 300));
        if (!((oH_ADDR == AW'(h)) && (oV_ADDR == AW'(v)))) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_pos: timeout at h=%0d v=%0d, wanted h=%0d v=%0d", oH_ADDR, oV_ADDR, h, v);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_sync"}, {60'd0, oHSYNC, oVSYNC, oDE, oFRAME_START}, 64'b1100);
        chk({tag, "_addr"}, {42'd0, oH_ADDR, oV_ADDR}, 64'd0);
        chk({tag, "_cfg"}, {40'd0, oVGAout_mode, oCURSOR_EN, oPOINT_X, oPOINT_Y}, 64'd0);
        chk({tag, "_ctl"}, {50'd0, oLINE_REQ, oLINE_NUM, oCFG_ACK, oUNDERFLOW}, 64'd0);
    endtask

    // Line-buffer loader model: ack one cycle after the request, late, or never
    initial begin
        forever begin
            @(negedge VCLK);
            iLINE_ACK = 1'b0;
            if (oLINE_REQ) begin
                if (int'(oLINE_NUM) == withhold_line) begin
                    iLINE_ACK = 1'b0;
                end else if (int'(oLINE_NUM) == late_line) begin
                    iLINE_ACK = (oH_ADDR == AW'(13));
                end else begin
                    iLINE_ACK = (oH_ADDR == AW'(9));
                end
            end
        end
    end

    // Monitor: compare every request, underflow rise and config ack with the scoreboard
    initial begin
        logic prev_req;
        logic prev_uf;
        req_t r;
        uf_t  u;
        cfg_t c;
        prev_req = 1'b0;
        prev_uf  = 1'b0;
        forever begin
            @(negedge VCLK);
            if (oLINE_REQ && !prev_req) begin
                if (req_q.size() == 0) begin
                    chk("req_unexpected", {31'd0, oV_ADDR, oH_ADDR, oLINE_NUM}, 64'd0);
                    chk("req_unexpected_flag", 64'd1, 64'd0);
                end else begin
                    r = req_q.pop_front();
                    cur_req = r;
                    have_cur = 1'b1;
                    chk("req_pos", {31'd0, oV_ADDR, oH_ADDR, oLINE_NUM}, {31'd0, r.v, r.h, r.num});
                end
            end else if (oLINE_REQ && prev_req && have_cur) begin
                chk("req_num_stable", {53'd0, oLINE_NUM}, {53'd0, cur_req.num});
            end else if (!oLINE_REQ && prev_req && have_cur) begin
                chk("req_fall", {42'd0, oV_ADDR, oH_ADDR}, {42'd0, oV_ADDR, cur_req.fall});
                have_cur = 1'b0;
            end
            if (oUNDERFLOW && !prev_uf) begin
                if (uf_q.size() == 0) begin
                    chk("uf_unexpected", {42'd0, oV_ADDR, oH_ADDR}, 64'hFFFF_FFFF);
                end else begin
                    u = uf_q.pop_front();
                    chk("uf_rise", {41'd0, oV_ADDR, oH_ADDR, oLINE_REQ}, {41'd0, u.v, u.h, u.req});
                end
            end
            if (oCFG_ACK) begin
                if (cfg_q.size() == 0) begin
                    chk("cfg_unexpected", {63'd0, oCFG_ACK}, 64'd0);
                end else begin
                    c = cfg_q.pop_front();
                    chk("cfg_ack", {39'd0, oFRAME_START, oVGAout_mode, oCURSOR_EN, oPOINT_X, oPOINT_Y},
                                   {39'd0, c.fs, c.mode, c.cur, c.x, c.y});
                end
            end
            prev_req = oLINE_REQ;
            prev_uf  = oUNDERFLOW;
        end
    end

    // Directed stimulus
    initial begin
        int eh;
        int ev;
        int n;
        logic de, hs, vs, fs;

        repeat (3) @(negedge VCLK);
        check_reset_state("reset");
        RST_N = 1'b1;
        @(negedge VCLK);
        chk("idle_outputs", {49'd0, oHSYNC, oVSYNC, oDE, oFRAME_START, oH_ADDR}, {49'd0, 4'b1100, 11'd0});

        // Config while stopped: load next edge, ack one cycle later
        iCFG_POINT_X = 11'd3; iCFG_POINT_Y = 11'd1; iCFG_MODE = 1'b0; iCFG_CURSOR_EN = 1'b1;
        iCFG_VALID = 1'b1;
        push_cfg(1'b0, 1'b0, 1'b1, 3, 1);
        n = 0;
        do begin
            @(negedge VCLK);
            n++;
        end while (!oCFG_ACK && n < 10);
        chk("cfg_idle_latency", 64'(n), 64'd2);
        iCFG_VALID = 1'b0;
        @(negedge VCLK);

        // Frame A: full raster check with prompt acks
        push_frame(10, 10, 10, 10);
        iEN = 1'b1;
        eh = 0;
        ev = 0;
        for (int k = 0; k < 99; k++) begin
            @(negedge VCLK);
            de = (eh < 8) && (ev < 4);
            hs = !((eh >= 10) && (eh < 12));
            vs = !(ev == 5);
            fs = (eh == 0) && (ev == 0);
            chk("raster", {38'd0, oH_ADDR, oV_ADDR, oDE, oHSYNC, oVSYNC, oFRAME_START},
                          {38'd0, AW'(eh), AW'(ev), de, hs, vs, fs});
            eh++;
            if (eh == 14) begin
                eh = 0;
                ev = (ev == 6) ? 0 : ev + 1;
            end
        end
        chk("no_uf_frame_a", {63'd0, oUNDERFLOW}, 64'd0);

        // Frame B: line 2 never acked; new config requested mid-frame
        withhold_line = 2;
        push_frame(10, 0, 10, 10);
        push_uf(2, 0);
        wait_pos(0, 1);
        iCFG_POINT_X = 11'd5; iCFG_POINT_Y = 11'd2; iCFG_MODE = 1'b1; iCFG_CURSOR_EN = 1'b0;
        iCFG_VALID = 1'b1;
        push_cfg(1'b1, 1'b1, 1'b0, 5, 2);
        wait_pos(1, 2);
        chk("uf_miss", {62'd0, oUNDERFLOW, oLINE_REQ}, 64'b10);
        wait_pos(5, 3);
        iUNDERFLOW_CLR = 1'b1;
        @(negedge VCLK);
        iUNDERFLOW_CLR = 1'b0;
        chk("uf_clear", {63'd0, oUNDERFLOW}, 64'd0);
        wait_pos(13, 6);
        chk("cfg_hold", {40'd0, oVGAout_mode, oCURSOR_EN, oPOINT_X, oPOINT_Y}, {40'd0, 1'b0, 1'b1, 11'd3, 11'd1});
        withhold_line = 3;
        late_line = 2;
        push_frame(10, 0, 0, 10);
        push_uf(3, 0);
        @(negedge VCLK);
        iCFG_VALID = 1'b0;

        // Frame C: line 2 acked on the deadline cycle, line 3 missed
        wait_pos(1, 2);
        chk("uf_ack_on_deadline", {62'd0, oUNDERFLOW, oLINE_REQ}, 64'b00);
        wait_pos(13, 6);
        chk("uf_miss2", {63'd0, oUNDERFLOW}, 64'd1);
        withhold_line = 1;
        late_line = -1;
        push_frame(0, 10, 10, 10);

        // Frame D: clear coincides with a new miss, then clear alone
        wait_pos(13, 0);
        iUNDERFLOW_CLR = 1'b1;
        @(negedge VCLK);
        iUNDERFLOW_CLR = 1'b0;
        chk("uf_set_wins", {62'd0, oUNDERFLOW, oLINE_REQ}, 64'b10);
        iUNDERFLOW_CLR = 1'b1;
        @(negedge VCLK);
        iUNDERFLOW_CLR = 1'b0;
        chk("uf_clear_alone", {63'd0, oUNDERFLOW}, 64'd0);
        wait_pos(13, 6);
        withhold_line = -1;
        push_req(0, 8, 1, 0);

        // Frame E: asynchronous reset while a request is open
        wait_pos(8, 0);
        chk("req_before_reset", {52'd0, oLINE_REQ, oLINE_NUM}, {52'd0, 1'b1, 11'd1});
        #2;
        RST_N = 1'b0;
        #1;
        check_reset_state("async_reset");
        @(negedge VCLK);
        @(negedge VCLK);
        RST_N = 1'b1;
        @(negedge VCLK);
        chk("restart", {40'd0, oFRAME_START, oDE, oH_ADDR, oV_ADDR}, {40'd0, 1'b1, 1'b1, 11'd0, 11'd0});
        @(negedge VCLK);
        chk("restart_next", {42'd0, oH_ADDR, oV_ADDR}, {42'd0, 11'd1, 11'd0});
        iEN = 1'b0;
        repeat (3) @(negedge VCLK);
        chk("scoreboard_empty", 64'(req_q.size() + uf_q.size() + cfg_q.size() + int'(have_cur)), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
